// File: rtl/display_pkg.sv
// Shared types and constants for the display arbitration slice.
package display_pkg;

    // Width of one display word: four hex nibbles.
    localparam int DIGIT_W = 16;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } disp_arb_state_t;

    // Requester index width; never narrower than one bit.
    function automatic int idx_width(input int n_req);
        idx_width = (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first asserted request
// scanning upward from (ptr + 1) mod N_REQ with wrap. When excl is set the
// requester at ptr (the current owner) is masked out of the scan.
import display_pkg::*;

module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             excl,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [N_REQ-1:0] masked_s;
    logic [31:0]      idx_s;

    // Mask the owner if asked, then scan from the slot after ptr with wrap.
    always_comb begin
        masked_s = req;
        winner   = '0;
        found    = 1'b0;
        idx_s    = 32'd0;
        if (excl) begin
            masked_s[ptr] = 1'b0;
        end else begin
            masked_s = req;
        end
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s = (32'(ptr) + 32'(k)) % 32'(N_REQ);
            if (!found && masked_s[idx_s[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = idx_s[IDX_W-1:0];
            end else begin
                found  = found;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit display. A new owner keeps the
// display for at least HOLD_CYCLES cycles (HOLD), after which it can be
// rotated out in favour of any other pending requester (OWN). All outputs
// are registered; grant and digito change on the same edge.
import display_pkg::*;

module display_arbiter #(
    parameter int                 N_REQ       = 3,
    parameter int                 HOLD_CYCLES = 13_500_000,
    parameter logic [DIGIT_W-1:0] IDLE_VALUE  = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [DIGIT_W*N_REQ-1:0] value,
    output logic [N_REQ-1:0]         grant,
    output logic                     owner_valid,
    output logic [DIGIT_W-1:0]       digito
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

    disp_arb_state_t    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               owner_valid_q, owner_valid_d;
    logic [DIGIT_W-1:0] digito_q, digito_d;

    logic               excl_s;
    logic [IDX_W-1:0]   win_s;
    logic               found_s;
    logic               owner_req_s;
    logic [DIGIT_W-1:0] owner_word_s;
    logic [DIGIT_W-1:0] win_word_s;

    // One-hot encode a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i == IDX_W'(k)) begin
                onehot[k] = 1'b1;
            end else begin
                onehot[k] = 1'b0;
            end
        end
    endfunction

    // Extract requester i's word from the packed value bus.
    function automatic logic [DIGIT_W-1:0] word_at(
        input logic [DIGIT_W*N_REQ-1:0] v,
        input logic [IDX_W-1:0]         i
    );
        word_at = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i == IDX_W'(k)) begin
                word_at = v[k*DIGIT_W +: DIGIT_W];
            end else begin
                word_at = word_at;
            end
        end
    endfunction

    // The owner is only excluded when deciding a rotation out of OWN;
    // in IDLE the pointer simply marks where the scan starts.
    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .excl   (excl_s),
        .winner (win_s),
        .found  (found_s)
    );

    // Owner request and words; the pointer always equals the current owner.
    always_comb begin
        excl_s       = (state_q == ST_OWN);
        owner_req_s  = req[ptr_q];
        owner_word_s = word_at(value, ptr_q);
        win_word_s   = word_at(value, win_s);
    end

    // Next-state logic for FSM, hold counter, pointer and output registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        digito_d = digito_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d  = ST_HOLD;
                    grant_d  = onehot(win_s);
                    digito_d = win_word_s;
                    cnt_d    = CNT_LOAD;
                    ptr_d    = win_s;
                end else begin
                    grant_d  = '0;
                    digito_d = IDLE_VALUE;
                end
            end
            ST_HOLD: begin
                // No preemption; the word freezes when the owner lets go.
                if (owner_req_s) begin
                    digito_d = owner_word_s;
                end else begin
                    digito_d = digito_q;
                end
                if (cnt_q == '0) begin
                    state_d = ST_OWN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (found_s) begin
                    // Someone else is waiting: hand over with no idle gap.
                    state_d  = ST_HOLD;
                    grant_d  = onehot(win_s);
                    digito_d = win_word_s;
                    cnt_d    = CNT_LOAD;
                    ptr_d    = win_s;
                end else if (owner_req_s) begin
                    digito_d = owner_word_s;
                end else begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    digito_d = IDLE_VALUE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                ptr_d    = PTR_RST;
                grant_d  = '0;
                digito_d = IDLE_VALUE;
            end
        endcase
        owner_valid_d = |grant_d;
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ptr_q         <= PTR_RST;
            grant_q       <= '0;
            owner_valid_q <= 1'b0;
            digito_q      <= IDLE_VALUE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            owner_valid_q <= owner_valid_d;
            digito_q      <= digito_d;
        end
    end

    assign grant       = grant_q;
    assign owner_valid = owner_valid_q;
    assign digito      = digito_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with N_REQ=3, HOLD_CYCLES=8,
// IDLE_VALUE=16'hFFFF. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_display_arbiter;

    localparam int N_REQ = 3;

    logic              clk;
    logic              rst;
    logic [N_REQ-1:0]  req;
    logic [47:0]       value;
    logic [N_REQ-1:0]  grant;
    logic              owner_valid;
    logic [15:0]       digito;

    int checks_s;
    int errors_s;

    display_arbiter #(
        .N_REQ       (N_REQ),
        .HOLD_CYCLES (8),
        .IDLE_VALUE  (16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .value       (value),
        .grant       (grant),
        .owner_valid (owner_valid),
        .digito      (digito)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            errors_s++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int i, input logic [15:0] w);
        value[i*16 +: 16] = w;
    endtask

    // Apply reset across one rising edge, releasing away from the edge.
    task automatic do_reset();
        rst = 1'b0;
        req = 3'b000;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        checks_s = 0;
        errors_s = 0;
        rst      = 1'b1;
        req      = 3'b000;
        value    = 48'd0;

        // 1: reset held with all requests asserted
        #2;
        rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 3; i++) tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(owner_valid), 32'h0);
        check("rst_digit", 32'(digito), 32'hFFFF);
        rst = 1'b1;
        req = 3'b000;
        tick();

        // 2: single requester, tracking and release
        do_reset();
        req = 3'b010;
        set_val(1, 16'h1234);
        tick();                                     // edge 1
        check("single_grant", 32'(grant), 32'h2);
        check("single_valid", 32'(owner_valid), 32'h1);
        check("single_digit", 32'(digito), 32'h1234);
        tick();                                     // edge 2
        tick();                                     // edge 3
        set_val(1, 16'h5678);
        tick();                                     // edge 4
        check("single_track", 32'(digito), 32'h5678);
        for (int e = 5; e <= 12; e++) tick();
        check("single_own_grant", 32'(grant), 32'h2);
        req = 3'b000;
        tick();                                     // edge 13
        check("single_rel_grant", 32'(grant), 32'h0);
        check("single_rel_valid", 32'(owner_valid), 32'h0);
        check("single_rel_digit", 32'(digito), 32'hFFFF);

        // 3: contention, lowest index first then handover without gap
        do_reset();
        set_val(0, 16'h1111);
        set_val(2, 16'h3333);
        req = 3'b101;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check("cont_first", 32'(grant), 32'h1);
        end
        tick();                                     // edge 10
        check("cont_switch_grant", 32'(grant), 32'h4);
        check("cont_switch_digit", 32'(digito), 32'h3333);
        check("cont_switch_valid", 32'(owner_valid), 32'h1);

        // 4: owner drops during HOLD, word freezes then idles
        do_reset();
        set_val(0, 16'h0C0C);
        req = 3'b001;
        tick();                                     // edge 1
        check("frz_grant", 32'(grant), 32'h1);
        tick();                                     // edge 2
        tick();                                     // edge 3
        req = 3'b000;
        set_val(0, 16'hABCD);
        for (int e = 4; e <= 9; e++) begin
            tick();
            check("frz_hold_digit", 32'(digito), 32'h0C0C);
        end
        tick();                                     // edge 10
        check("frz_end_digit", 32'(digito), 32'hFFFF);
        check("frz_end_grant", 32'(grant), 32'h0);

        // 5: continuous three-way rotation, 9 cycles per owner
        do_reset();
        set_val(0, 16'hA000);
        set_val(1, 16'hB001);
        set_val(2, 16'hC002);
        req = 3'b111;
        for (int e = 1; e <= 36; e++) begin
            logic [2:0] exp_g;
            logic [15:0] exp_d;
            case ((e - 1) / 9)
                0:       begin exp_g = 3'b001; exp_d = 16'hA000; end
                1:       begin exp_g = 3'b010; exp_d = 16'hB001; end
                2:       begin exp_g = 3'b100; exp_d = 16'hC002; end
                default: begin exp_g = 3'b001; exp_d = 16'hA000; end
            endcase
            tick();
            check("rot_grant", 32'(grant), 32'(exp_g));
            check("rot_digit", 32'(digito), 32'(exp_d));
        end

        // 6: asynchronous reset mid-HOLD, pointer returns to reset value
        do_reset();
        set_val(1, 16'h2222);
        req = 3'b010;
        tick();
        tick();
        check("mid_pre_grant", 32'(grant), 32'h2);
        rst = 1'b0;
        #2;
        check("mid_async_grant", 32'(grant), 32'h0);
        check("mid_async_valid", 32'(owner_valid), 32'h0);
        check("mid_async_digit", 32'(digito), 32'hFFFF);
        req = 3'b110;
        tick();
        rst = 1'b1;
        tick();
        check("mid_regrant", 32'(grant), 32'h2);
        check("mid_regrant_digit", 32'(digito), 32'h2222);

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end

endmodule
